// File: rtl/decode_exec_pkg.sv
// decode_exec_pkg: opcodes, ALU operation codes and ALUOp encodings for decode_exec_unit.
package decode_exec_pkg;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [4:0] OPAND   = 5'd0;
    localparam logic [4:0] OPOR    = 5'd1;
    localparam logic [4:0] OPXOR   = 5'd2;
    localparam logic [4:0] OPADD   = 5'd3;
    localparam logic [4:0] OPSUB   = 5'd4;
    localparam logic [4:0] OPSLT   = 5'd5;
    localparam logic [4:0] OPSLTU  = 5'd6;
    localparam logic [4:0] OPSLL   = 5'd7;
    localparam logic [4:0] OPSRL   = 5'd8;
    localparam logic [4:0] OPSRA   = 5'd9;
    localparam logic [4:0] OPPASSB = 5'd10;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_R     = 3'b010;
    localparam logic [2:0] ALUOP_I     = 3'b011;
    localparam logic [2:0] ALUOP_PASSB = 3'b100;

    typedef struct packed {
        logic       mem2reg;
        logic       le_mem;
        logic       escreve_mem;
        logic       branch;
        logic       jump;
        logic       orig_ula;
        logic       escreve_reg;
        logic [2:0] alu_op;
    } ctrl_t;
endpackage

// File: rtl/alu32.sv
// alu32: combinational 32-bit ALU with zero flag.
module alu32
    import decode_exec_pkg::*;
(
    input  logic [4:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);
    always_comb begin
        result = '0;
        case (ctrl)
            OPAND:   result = a & b;
            OPOR:    result = a | b;
            OPXOR:   result = a ^ b;
            OPADD:   result = a + b;
            OPSUB:   result = a - b;
            OPSLT:   result = {31'b0, $signed(a) < $signed(b)};
            OPSLTU:  result = {31'b0, a < b};
            OPSLL:   result = a << b[4:0];
            OPSRL:   result = a >> b[4:0];
            OPSRA:   result = $unsigned($signed(a) >>> b[4:0]);
            OPPASSB: result = b;
            default: result = '0;
        endcase
    end
    assign zero = result == '0;
endmodule

// File: rtl/decode_exec_unit.sv
// decode_exec_unit: registered control decode, ALU-control decode and ALU for the RV32I subset core.
module decode_exec_unit
    import decode_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clockCPU,
    input  logic            reset,
    input  logic [31:0]     iInstr,
    input  logic [XLEN-1:0] iA,
    input  logic [XLEN-1:0] iRs2,
    input  logic [XLEN-1:0] iImm,
    output logic            oMem2Reg,
    output logic            oLeMem,
    output logic            oEscreveMem,
    output logic            oBranch,
    output logic            oJump,
    output logic            oOrigULA,
    output logic            oEscreveReg,
    output logic [2:0]      oALUOp,
    output logic [4:0]      oALUControl,
    output logic [XLEN-1:0] oResult,
    output logic            oZero
);
    ctrl_t           ctrl_d, ctrl_q;
    logic [4:0]      alu_control_d, alu_control_q, funct_op;
    logic [XLEN-1:0] result_d, result_q, op_b;
    logic            zero_d, zero_q, alt;
    logic            unused_bits;

    assign unused_bits = ^{iInstr[24:15], iInstr[11:7]};
    assign alt = iInstr[31:25] == 7'b0100000;

    always_comb begin
        ctrl_d = '0;
        case (iInstr[6:0])
            OPC_R:      begin ctrl_d.escreve_reg = 1'b1; ctrl_d.alu_op = ALUOP_R; end
            OPC_IMM:    begin ctrl_d.escreve_reg = 1'b1; ctrl_d.orig_ula = 1'b1; ctrl_d.alu_op = ALUOP_I; end
            OPC_LOAD:   begin
                ctrl_d.le_mem = 1'b1;
                ctrl_d.mem2reg = 1'b1;
                ctrl_d.escreve_reg = 1'b1;
                ctrl_d.orig_ula = 1'b1;
            end
            OPC_STORE:  begin ctrl_d.escreve_mem = 1'b1; ctrl_d.orig_ula = 1'b1; end
            OPC_BRANCH: begin ctrl_d.branch = 1'b1; ctrl_d.alu_op = ALUOP_SUB; end
            OPC_JAL:    begin ctrl_d.jump = 1'b1; ctrl_d.escreve_reg = 1'b1; end
            OPC_JALR:   begin ctrl_d.jump = 1'b1; ctrl_d.escreve_reg = 1'b1; ctrl_d.orig_ula = 1'b1; end
            OPC_LUI:    begin ctrl_d.escreve_reg = 1'b1; ctrl_d.orig_ula = 1'b1; ctrl_d.alu_op = ALUOP_PASSB; end
            default:    ctrl_d = '0;
        endcase
    end

    // SUB via funct7 only exists for register-register ops; ADDI ignores funct7
    always_comb begin
        funct_op = OPADD;
        case (iInstr[14:12])
            3'b000: funct_op = (ctrl_d.alu_op == ALUOP_R && alt) ? OPSUB : OPADD;
            3'b001: funct_op = OPSLL;
            3'b010: funct_op = OPSLT;
            3'b011: funct_op = OPSLTU;
            3'b100: funct_op = OPXOR;
            3'b101: funct_op = alt ? OPSRA : OPSRL;
            3'b110: funct_op = OPOR;
            default: funct_op = OPAND;
        endcase
        alu_control_d = ctrl_d.alu_op == ALUOP_SUB   ? OPSUB :
                        ctrl_d.alu_op == ALUOP_PASSB ? OPPASSB :
                        (ctrl_d.alu_op == ALUOP_R || ctrl_d.alu_op == ALUOP_I) ? funct_op : OPADD;
        op_b = ctrl_d.orig_ula ? iImm : iRs2;
    end

    alu32 u_alu (
        .ctrl   (alu_control_d),
        .a      (iA),
        .b      (op_b),
        .result (result_d),
        .zero   (zero_d)
    );

    always_ff @(posedge clockCPU) begin
        if (reset) begin
            ctrl_q        <= '0;
            alu_control_q <= '0;
            result_q      <= '0;
            zero_q        <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            alu_control_q <= alu_control_d;
            result_q      <= result_d;
            zero_q        <= zero_d;
        end
    end

    assign oMem2Reg    = ctrl_q.mem2reg;
    assign oLeMem      = ctrl_q.le_mem;
    assign oEscreveMem = ctrl_q.escreve_mem;
    assign oBranch     = ctrl_q.branch;
    assign oJump       = ctrl_q.jump;
    assign oOrigULA    = ctrl_q.orig_ula;
    assign oEscreveReg = ctrl_q.escreve_reg;
    assign oALUOp      = ctrl_q.alu_op;
    assign oALUControl = alu_control_q;
    assign oResult     = result_q;
    assign oZero       = zero_q;
endmodule

// File: tb/tb_decode_exec_unit.sv
// tb_decode_exec_unit: randomized scoreboard bench for decode_exec_unit against an instruction-level model.
module tb_decode_exec_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0, a = '0, rs2 = '0, imm = '0;
    logic        mem2reg, le_mem, escreve_mem, branch, jump, orig_ula, escreve_reg, zero;
    logic [2:0]  alu_op;
    logic [4:0]  alu_control;
    logic [31:0] result;

    typedef struct {
        logic [6:0]  c;
        logic [2:0]  op;
        logic [4:0]  ac;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   f3_code[8] = '{3, 7, 5, 6, 2, 8, 1, 0};
    logic [6:0] opcodes[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h7F};

    always #5 clk = ~clk;

    decode_exec_unit #(.XLEN(32)) dut (
        .clockCPU(clk), .reset(rst), .iInstr(instr), .iA(a), .iRs2(rs2), .iImm(imm),
        .oMem2Reg(mem2reg), .oLeMem(le_mem), .oEscreveMem(escreve_mem), .oBranch(branch),
        .oJump(jump), .oOrigULA(orig_ula), .oEscreveReg(escreve_reg), .oALUOp(alu_op),
        .oALUControl(alu_control), .oResult(result), .oZero(zero)
    );

    // Controls packed as {mem2reg, le_mem, escreve_mem, branch, jump, orig_ula, escreve_reg}
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] k, input logic r);
        exp_t e;
        logic [31:0] b;
        int code;
        e = '{c: '0, op: '0, ac: '0, r: '0, z: 1'b0};
        if (r) return e;
        case (i[6:0])
            7'h33: begin e.c = 7'b0000001; e.op = 3'd2; end
            7'h13: begin e.c = 7'b0000011; e.op = 3'd3; end
            7'h03: e.c = 7'b1100011;
            7'h23: e.c = 7'b0010010;
            7'h63: begin e.c = 7'b0001000; e.op = 3'd1; end
            7'h6F: e.c = 7'b0000101;
            7'h67: e.c = 7'b0000111;
            7'h37: begin e.c = 7'b0000011; e.op = 3'd4; end
            default: ;
        endcase
        b = e.c[1] ? k : y;
        code = e.op == 3'd1 ? 4 : e.op == 3'd4 ? 10 : e.op >= 3'd2 ? f3_code[i[14:12]] : 3;
        if ((e.op == 3'd2 || e.op == 3'd3) && i[31:25] == 7'h20 &&
            (i[14:12] == 3'd5 || (i[14:12] == 3'd0 && e.op == 3'd2)))
            code = code + 1;
        e.ac = code[4:0];
        case (code)
            0: e.r = x & b;
            1: e.r = x | b;
            2: e.r = x ^ b;
            3: e.r = x + b;
            4: e.r = x - b;
            5: e.r = ($signed(x) < $signed(b)) ? 32'd1 : 32'd0;
            6: e.r = (x < b) ? 32'd1 : 32'd0;
            7: e.r = x << b[4:0];
            8: e.r = x >> b[4:0];
            9: e.r = $unsigned($signed(x) >>> b[4:0]);
            10: e.r = b;
            default: e.r = '0;
        endcase
        e.z = e.r == 0;
        return e;
    endfunction

    task automatic issue(input logic [31:0] i, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] k, input logic r);
        exp_t e;
        instr = i; a = x; rs2 = y; imm = k; rst = r;
        e = model(i, x, y, k, r);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (instr 0x%08h)", name, act, req, instr);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ctrl", {25'b0, mem2reg, le_mem, escreve_mem, branch, jump, orig_ula, escreve_reg}, {25'b0, e.c});
            check("aluop", {29'b0, alu_op}, {29'b0, e.op});
            check("aluctrl", {27'b0, alu_control}, {27'b0, e.ac});
            check("result", result, e.r);
            check("zero", {31'b0, zero}, {31'b0, e.z});
        end
    end

    initial begin
        logic [31:0] ri;
        logic [6:0]  f7;
        issue(32'h002081B3, 32'd3, 32'd4, 32'd0, 1'b1);
        issue(32'h002081B3, 32'd3, 32'd4, 32'd0, 1'b1);
        issue(32'h002081B3, 32'd3, 32'd4, 32'd0, 1'b0);
        issue(32'h40208033, 32'd5, 32'd7, 32'd0, 1'b0);
        issue(32'h00208463, 32'h1234, 32'h1234, 32'd8, 1'b0);
        issue(32'h00208463, 32'h1234, 32'h1235, 32'd8, 1'b0);
        issue(32'h4010D093, 32'h80000000, 32'd0, 32'h401, 1'b0);
        issue(32'h0010D093, 32'h80000000, 32'd0, 32'h1, 1'b0);
        issue(32'h0080A183, 32'h100, 32'h55, 32'd8, 1'b0);
        issue(32'h0030A423, 32'h100, 32'h55, 32'd8, 1'b0);
        issue(32'h000080E7, 32'h2000, 32'h3, 32'h10, 1'b0);
        issue(32'h123450B7, 32'h77, 32'h3, 32'h12345000, 1'b0);
        issue(32'h0000007F, 32'h9, 32'h9, 32'h9, 1'b0);
        issue(32'h0020A1B3, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
        issue(32'h0020B1B3, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
        issue(32'h0020A1B3, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            ri = $urandom;
            ri[6:0] = opcodes[$urandom_range(0, 8)];
            f7 = ($urandom_range(0, 3) == 0) ? ri[31:25] : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
            ri[31:25] = f7;
            issue(ri, $urandom_range(0, 3) == 0 ? 32'h80000000 : $urandom,
                  $urandom_range(0, 3) == 0 ? 32'd0 : $urandom, $urandom, $urandom_range(0, 49) == 0);
        end
        rst = 1'b0;
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
